// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   localparam int unsigned DEF_WIDTH = 4;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor cell: d = x - y - br, with borrow-out.
module full_subtractor_bit (
   input  logic x_i,
   input  logic y_i,
   input  logic br_i,
   output logic d_o,
   output logic br_next_o
);

   assign d_o       = x_i ^ y_i ^ br_i;
   assign br_next_o = (~x_i & y_i) | (~(x_i ^ y_i) & br_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: {bout, diff} = a - b - bin.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             done_q, done_d;
   logic             d_bit;
   logic             br_nx;

   full_subtractor_bit u_cell (
      .x_i       (a_q[0]),
      .y_i       (b_q[0]),
      .br_i      (br_q),
      .d_o       (d_bit),
      .br_next_o (br_nx)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      dsr_d   = dsr_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               br_d    = bin_i;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            dsr_d = {d_bit, dsr_q[WIDTH-1:1]};
            br_d  = br_nx;
            cnt_d = cnt_q + CW'(1);
            // Last bit: publish the completed shift register
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d  = {d_bit, dsr_q[WIDTH-1:1]};
               bout_d  = br_nx;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         dsr_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dsr_q   <= dsr_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = done_q;
   assign diff_o = diff_q;
   assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start_i = 1'b0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         bin_i = 1'b0;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] diff_o;
   logic         bout_o;

   int total = 0;
   int bad   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .bin_i   (bin_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .diff_o  (diff_o),
      .bout_o  (bout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] ref_sub(input int a, input int b,
                                          input int bi);
      int r;
      r = a - b - bi;
      return (W+1)'(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done_o && lat < W + 4) begin
         tick();
         lat++;
      end
   endtask

   task automatic count_dones(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (done_o) cnt++;
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi);
      logic [W:0] prev;
      logic [W:0] exp;
      int         lat;
      prev    = {bout_o, diff_o};
      exp     = ref_sub(int'(a), int'(b), int'(bi));
      start_i = 1'b1;
      a_i     = a;
      b_i     = b;
      bin_i   = bi;
      tick();
      start_i = 1'b0;
      a_i     = W'($urandom);
      b_i     = W'($urandom);
      bin_i   = 1'($urandom);
      check("busy_up", busy_o, 1);
      check("hold", {bout_o, diff_o}, prev);
      wait_done(lat);
      check("latency", lat, W);
      check("result", {bout_o, diff_o}, exp);
      check("busy_dn", busy_o, 0);
      tick();
      check("done_drop", done_o, 0);
   endtask

   initial begin
      int lat;
      int cnt;
      logic [W:0] exp;

      #3;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_res", {bout_o, diff_o}, 0);
      tick();
      rst = 1'b0;
      tick();

      do_op(4'b0000, 4'b0000, 1'b0);
      do_op(4'b0110, 4'b0001, 1'b1);
      do_op(4'b0011, 4'b1101, 1'b1);
      do_op(4'b0000, 4'b0000, 1'b1);

      // start held high across two operations
      start_i = 1'b1;
      a_i     = 4'b1101;
      b_i     = 4'b0110;
      bin_i   = 1'b1;
      tick();
      a_i     = 4'b1101;
      b_i     = 4'b1100;
      bin_i   = 1'b1;
      wait_done(lat);
      check("b2b_lat1", lat, W);
      check("b2b_res1", {bout_o, diff_o}, 5'b0_0110);
      tick();
      start_i = 1'b0;
      check("b2b_drop", done_o, 0);
      check("b2b_busy", busy_o, 1);
      wait_done(lat);
      check("b2b_gap", lat + 1, W + 1);
      check("b2b_res2", {bout_o, diff_o}, 5'b0_0000);
      tick();

      // start pulse during RUN is ignored
      start_i = 1'b1;
      a_i     = 4'b1001;
      b_i     = 4'b0011;
      bin_i   = 1'b0;
      tick();
      start_i = 1'b0;
      tick();
      start_i = 1'b1;
      a_i     = 4'b0000;
      b_i     = 4'b1111;
      bin_i   = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done(lat);
      check("ign_lat", lat + 2, W);
      check("ign_res", {bout_o, diff_o}, 5'b0_0110);
      count_dones(10, cnt);
      check("ign_extra", cnt, 0);

      // asynchronous reset mid-RUN
      start_i = 1'b1;
      a_i     = 4'b1111;
      b_i     = 4'b0001;
      bin_i   = 1'b0;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_done", done_o, 0);
      check("arst_res", {bout_o, diff_o}, 0);
      tick();
      rst = 1'b0;
      count_dones(10, cnt);
      check("arst_nodone", cnt, 0);
      do_op(4'b0110, 4'b0001, 1'b1);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int bi = 0; bi < 2; bi++)
               do_op(W'(a), W'(b), 1'(bi));

      for (int i = 0; i < 60; i++)
         do_op(W'($urandom), W'($urandom), 1'($urandom));

      exp = ref_sub(0, 0, 1);
      check("model_wrap", {bout_o, diff_o} | 5'b0, {bout_o, diff_o});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
